// File: rtl/rv_alu.sv
// Registered RV32 integer ALU: eleven operations selected by alu_ctrl, one-cycle latency.
// Define ALU_FLAGS_EN to add registered carry/overflow/negative outputs.
module rv_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            alu_ctrl,
`ifdef ALU_FLAGS_EN
  output logic                  carry,
  output logic                  overflow,
  output logic                  negative,
`endif
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  localparam int MSB     = DATA_WIDTH - 1;

  logic signed [DATA_WIDTH-1:0] a_s;
  logic signed [DATA_WIDTH-1:0] b_s;
  logic        [SHAMT_W-1:0]    shamt;
  logic        [DATA_WIDTH-1:0] sum;
  logic        [DATA_WIDTH-1:0] diff;
  logic        [DATA_WIDTH-1:0] result_d;
  logic        [DATA_WIDTH-1:0] result_p0;
  logic                         zero_p0;

  assign a_s   = $signed(a);
  assign b_s   = $signed(b);
  assign shamt = b[SHAMT_W-1:0];

`ifdef ALU_FLAGS_EN
  // One extra bit captures carry-out of ADD and borrow of SUB.
  logic [DATA_WIDTH:0] sum_ext;
  logic [DATA_WIDTH:0] diff_ext;
  logic                carry_d;
  logic                overflow_d;
  logic                carry_p0;
  logic                overflow_p0;
  logic                negative_p0;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign sum      = sum_ext[MSB:0];
  assign diff     = diff_ext[MSB:0];

  always_comb begin
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (alu_ctrl)
      4'h0: begin
        carry_d    = sum_ext[DATA_WIDTH];
        overflow_d = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      4'h1: begin
        carry_d    = ~diff_ext[DATA_WIDTH];
        overflow_d = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      default: ;
    endcase
  end
`else
  assign sum  = a + b;
  assign diff = a - b;
`endif

  function automatic logic [DATA_WIDTH-1:0] flag_word(input logic bit_in);
    flag_word = {{(DATA_WIDTH-1){1'b0}}, bit_in};
  endfunction

  always_comb begin
    result_d = '0;
    case (alu_ctrl)
      4'h0:    result_d = sum;
      4'h1:    result_d = diff;
      4'h2:    result_d = a & b;
      4'h3:    result_d = a | b;
      4'h4:    result_d = a ^ b;
      4'h5:    result_d = a << shamt;
      4'h6:    result_d = a >> shamt;
      4'h7:    result_d = $unsigned(a_s >>> shamt);
      4'h8:    result_d = flag_word(a_s < b_s);
      4'h9:    result_d = flag_word(a < b);
      4'hA:    result_d = b;
      default: result_d = '0;
    endcase
  end

  // Stage p0: output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p0 <= '0;
      zero_p0   <= 1'b1;
    end else begin
      result_p0 <= result_d;
      zero_p0   <= (result_d == '0);
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_p0    <= 1'b0;
      overflow_p0 <= 1'b0;
      negative_p0 <= 1'b0;
    end else begin
      carry_p0    <= carry_d;
      overflow_p0 <= overflow_d;
      negative_p0 <= result_d[MSB];
    end
  end

  assign carry    = carry_p0;
  assign overflow = overflow_p0;
  assign negative = negative_p0;
`endif

  assign result = result_p0;
  assign zero   = zero_p0;

endmodule

// File: tb/tb_rv_alu.sv
// Self-checking bench for rv_alu (default build, DATA_WIDTH=32): directed cases
// plus randomized operations against a plain-arithmetic reference model.
module tb_rv_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_alu #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .alu_ctrl (alu_ctrl),
    .result   (result),
    .zero     (zero)
  );

  // Reference model straight from the opcode table, using 32-bit int arithmetic.
  function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] op);
    int          sx = x;
    int          sy = y;
    int unsigned ux = x;
    int unsigned uy = y;
    int unsigned sh = uy % 32;
    case (op)
      4'd0:    return ux + uy;
      4'd1:    return ux - uy;
      4'd2:    return x & y;
      4'd3:    return x | y;
      4'd4:    return x ^ y;
      4'd5:    return ux << sh;
      4'd6:    return ux >> sh;
      4'd7:    return sx >>> sh;
      4'd8:    return (sx < sy) ? 32'd1 : 32'd0;
      4'd9:    return (ux < uy) ? 32'd1 : 32'd0;
      4'd10:   return y;
      default: return 32'd0;
    endcase
  endfunction

  // Present one operation and advance to just after the edge that captures it.
  task automatic cycle(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    a = x;
    b = y;
    alu_ctrl = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(32'd5, 32'd5, 4'h0);
    @(posedge clk);
    #1;
    checks++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold result=%h zero=%b expected result=00000000 zero=1", result, zero);
    end
    rst = 1'b0;
    cycle(32'd5, 32'd5, 4'h0);
    checks++;
    if (result !== 32'd10 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_release result=%h zero=%b expected result=0000000a zero=0", result, zero);
    end
  endtask

  task automatic test_add_sub();
    logic [31:0] xa [4] = '{32'd3, 32'd7, 32'd4, 32'hFFFF_FFFF};
    logic [31:0] ya [4] = '{32'd4, 32'd4, 32'd7, 32'd1};
    logic [3:0]  oa [4] = '{4'h0, 4'h1, 4'h1, 4'h0};
    logic [31:0] ea [4] = '{32'd7, 32'd3, 32'hFFFF_FFFD, 32'd0};
    for (int i = 0; i < 4; i++) begin
      cycle(xa[i], ya[i], oa[i]);
      checks++;
      if (result !== ea[i] || zero !== (ea[i] == 32'd0)) begin
        errors++;
        $display("FAIL add_sub[%0d] result=%h zero=%b expected %h zero=%b",
                 i, result, zero, ea[i], ea[i] == 32'd0);
      end
    end
  endtask

  task automatic test_logic();
    logic [31:0] xa [4] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0};
    logic [31:0] ya [4] = '{32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h12345000};
    logic [3:0]  oa [4] = '{4'h2, 4'h3, 4'h4, 4'hA};
    logic [31:0] ea [4] = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h12345000};
    for (int i = 0; i < 4; i++) begin
      cycle(xa[i], ya[i], oa[i]);
      checks++;
      if (result !== ea[i] || zero !== 1'b0) begin
        errors++;
        $display("FAIL logic[%0d] result=%h zero=%b expected %h zero=0", i, result, zero, ea[i]);
      end
    end
  endtask

  task automatic test_shifts();
    logic [31:0] ya [6] = '{32'h24, 32'h24, 32'h24, 32'h0, 32'h0, 32'h0};
    logic [3:0]  oa [6] = '{4'h5, 4'h6, 4'h7, 4'h5, 4'h6, 4'h7};
    logic [31:0] ea [6] = '{32'h00000010, 32'h08000000, 32'hF8000000,
                            32'h80000001, 32'h80000001, 32'h80000001};
    for (int i = 0; i < 6; i++) begin
      cycle(32'h80000001, ya[i], oa[i]);
      checks++;
      if (result !== ea[i]) begin
        errors++;
        $display("FAIL shift[%0d] result=%h expected %h", i, result, ea[i]);
      end
    end
  endtask

  task automatic test_compares();
    logic [31:0] xa [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd9, 32'd9, 32'd9, 32'd9};
    logic [31:0] ya [8] = '{32'd1, 32'd1, 32'd5, 32'd5, 32'd3, 32'd3, 32'd3, 32'd3};
    logic [3:0]  oa [8] = '{4'h8, 4'h9, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF};
    logic [31:0] ea [8] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 8; i++) begin
      cycle(xa[i], ya[i], oa[i]);
      checks++;
      if (result !== ea[i] || zero !== (ea[i] == 32'd0)) begin
        errors++;
        $display("FAIL compare[%0d] result=%h zero=%b expected %h zero=%b",
                 i, result, zero, ea[i], ea[i] == 32'd0);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] corner [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] x, y, exp;
    logic [3:0]  op;
    for (int i = 0; i < 300; i++) begin
      x  = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      y  = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      op = 4'($urandom_range(0, 15));
      exp = ref_alu(x, y, op);
      cycle(x, y, op);
      checks++;
      if (result !== exp || zero !== (exp == 32'd0)) begin
        errors++;
        $display("FAIL random op=%h a=%h b=%h result=%h zero=%b expected %h", op, x, y, result, zero, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y, exp;
    logic [3:0]  op;
    for (int i = 0; i < 24; i++) begin
      x  = $urandom;
      y  = $urandom;
      op = 4'(i % 11);
      rst = (i == 12);
      exp = rst ? 32'd0 : ref_alu(x, y, op);
      cycle(x, y, op);
      checks++;
      if (result !== exp || zero !== (exp == 32'd0)) begin
        errors++;
        $display("FAIL back_to_back[%0d] rst=%b op=%h result=%h zero=%b expected %h",
                 i, rst, op, result, zero, exp);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a = '0;
    b = '0;
    alu_ctrl = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_add_sub();
    test_logic();
    test_shifts();
    test_compares();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
